// File: rtl/clock_time_keeper.sv
// clock_time_keeper: BCD hours/minutes/seconds keeper with key-driven set mode.
// Feeds the six-digit seven-segment display path with a registered time bus,
// a field-blink select and a one-cycle day rollover pulse.
//
// state  | meaning
// RUN    | time advances on each prescaler tick, blink = 0
// SET_HH | hours adjustable with key_inc, blink = 3
// SET_MM | minutes adjustable with key_inc, blink = 2
// SET_SS | seconds adjustable with key_inc, blink = 1
module clock_time_keeper #(
    parameter int         DIV_COUNT = 50_000_000,
    parameter logic [7:0] INIT_HH   = 8'h00,
    parameter logic [7:0] INIT_MM   = 8'h00,
    parameter logic [7:0] INIT_SS   = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_mode,
    input  logic        key_inc,
    output logic [23:0] time_date,
    output logic [1:0]  blink,
    output logic        day_carry
);

    localparam int            PW = $clog2(DIV_COUNT);
    localparam logic [PW-1:0] TC = PW'(DIV_COUNT - 1);

    typedef enum logic [1:0] {RUN, SET_HH, SET_MM, SET_SS} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_hh, r_mm, r_ss;
    logic [7:0]    w_hh_nxt, w_mm_nxt, w_ss_nxt;
    logic [1:0]    r_blink;
    logic [1:0]    w_blink_nxt;
    logic          r_day_carry;
    logic          w_day_carry_nxt;
    logic          r_mode_prev, r_inc_prev, r_armed;
    logic          w_mode_edge, w_inc_edge, w_tick;
    logic [8:0]    w_hh_inc, w_mm_inc, w_ss_inc;

    // Returns {carry, next}. Malformed values (bad nibble or above max) snap to 00
    // without carrying into the neighbouring field.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
        logic [8:0] res;
        if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v > maxv))
            res = 9'h000;
        else if (v == maxv)
            res = {1'b1, 8'h00};
        else if (v[3:0] == 4'd9)
            res = {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            res = {1'b0, v[7:4], v[3:0] + 4'd1};
        return res;
    endfunction

    // r_armed is clear for the first clock after reset, so a key already high
    // when reset releases loads into prev without being seen as an edge.
    assign w_mode_edge = r_armed & key_mode & ~r_mode_prev;
    assign w_inc_edge  = r_armed & key_inc & ~r_inc_prev;
    assign w_tick      = (r_state == RUN) && (r_presc == TC);

    assign w_hh_inc = bcd_inc(r_hh, 8'h23);
    assign w_mm_inc = bcd_inc(r_mm, 8'h59);
    assign w_ss_inc = bcd_inc(r_ss, 8'h59);

    assign time_date = {r_hh, r_mm, r_ss};
    assign blink     = r_blink;
    assign day_carry = r_day_carry;

    // Key history for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_prev <= 1'b0;
            r_inc_prev  <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_mode_prev <= key_mode;
            r_inc_prev  <= key_inc;
            r_armed     <= 1'b1;
        end
    end

    // One-second prescaler; parked at zero while any field is being set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_presc <= '0;
        else if ((r_state != RUN) || w_tick)
            r_presc <= '0;
        else
            r_presc <= r_presc + 1'b1;
    end

    // Next state, next time fields and blink code.
    always_comb begin
        w_state_nxt     = r_state;
        w_hh_nxt        = r_hh;
        w_mm_nxt        = r_mm;
        w_ss_nxt        = r_ss;
        w_day_carry_nxt = 1'b0;
        w_blink_nxt     = 2'd0;
        case (r_state)
            RUN: begin
                if (w_tick) begin
                    w_ss_nxt = w_ss_inc[7:0];
                    if (w_ss_inc[8]) begin
                        w_mm_nxt = w_mm_inc[7:0];
                        if (w_mm_inc[8]) begin
                            w_hh_nxt        = w_hh_inc[7:0];
                            w_day_carry_nxt = w_hh_inc[8];
                        end
                    end
                end
                if (w_mode_edge) w_state_nxt = SET_HH;
            end
            SET_HH: begin
                if (w_mode_edge)     w_state_nxt = SET_MM;
                else if (w_inc_edge) w_hh_nxt    = w_hh_inc[7:0];
            end
            SET_MM: begin
                if (w_mode_edge)     w_state_nxt = SET_SS;
                else if (w_inc_edge) w_mm_nxt    = w_mm_inc[7:0];
            end
            SET_SS: begin
                if (w_mode_edge)     w_state_nxt = RUN;
                else if (w_inc_edge) w_ss_nxt    = w_ss_inc[7:0];
            end
            default: w_state_nxt = RUN;
        endcase
        case (w_state_nxt)
            SET_HH:  w_blink_nxt = 2'd3;
            SET_MM:  w_blink_nxt = 2'd2;
            SET_SS:  w_blink_nxt = 2'd1;
            default: w_blink_nxt = 2'd0;
        endcase
    end

    // State register with blink updated on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_blink <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_blink <= w_blink_nxt;
        end
    end

    // Time fields and rollover pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hh        <= INIT_HH;
            r_mm        <= INIT_MM;
            r_ss        <= INIT_SS;
            r_day_carry <= 1'b0;
        end else begin
            r_hh        <= w_hh_nxt;
            r_mm        <= w_mm_nxt;
            r_ss        <= w_ss_nxt;
            r_day_carry <= w_day_carry_nxt;
        end
    end

endmodule

// File: tb/tb_clock_time_keeper.sv
// Testbench for clock_time_keeper: decimal reference model feeds a scoreboard
// queue each cycle; DUT outputs are popped and compared #1 after the edge.
module tb_clock_time_keeper;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_mode;
    logic        key_inc;
    logic [23:0] time_date;
    logic [1:0]  blink;
    logic        day_carry;

    typedef struct packed {
        logic [23:0] t;
        logic [1:0]  b;
        logic        dc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    int mhh, mmm, mss, mst, mpresc;
    bit mpm, mpi, marm, mdc;

    clock_time_keeper #(
        .DIV_COUNT(DIV),
        .INIT_HH  (8'h12),
        .INIT_MM  (8'h34),
        .INIT_SS  (8'h56)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_mode (key_mode),
        .key_inc  (key_inc),
        .time_date(time_date),
        .blink    (blink),
        .day_carry(day_carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        mhh = 12; mmm = 34; mss = 56;
        mst = 0; mpresc = 0;
        mpm = 0; mpi = 0; marm = 0; mdc = 0;
    endtask

    // Reference behaviour for one rising edge with the given key levels.
    task automatic model_step(input bit km, input bit ki);
        bit me, ie, tk;
        me   = marm && km && !mpm;
        ie   = marm && ki && !mpi;
        mpm  = km;
        mpi  = ki;
        marm = 1;
        mdc  = 0;
        if (mst == 0) begin
            tk     = (mpresc == DIV - 1);
            mpresc = tk ? 0 : mpresc + 1;
            if (tk) begin
                mss++;
                if (mss == 60) begin
                    mss = 0; mmm++;
                    if (mmm == 60) begin
                        mmm = 0; mhh++;
                        if (mhh == 24) begin mhh = 0; mdc = 1; end
                    end
                end
            end
        end else begin
            mpresc = 0;
            if (ie && !me) begin
                case (mst)
                    1: mhh = (mhh + 1) % 24;
                    2: mmm = (mmm + 1) % 60;
                    default: mss = (mss + 1) % 60;
                endcase
            end
        end
        if (me) mst = (mst + 1) % 4;
    endtask

    task automatic cyc(input bit km, input bit ki);
        exp_t e;
        key_mode = km;
        key_inc  = ki;
        model_step(km, ki);
        e.t  = {to_bcd(mhh), to_bcd(mmm), to_bcd(mss)};
        e.b  = (mst == 0) ? 2'd0 : 2'(4 - mst);
        e.dc = mdc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("time_date", 32'(time_date), 32'(e.t));
        check("blink", 32'(blink), 32'(e.b));
        check("day_carry", 32'(day_carry), 32'(e.dc));
    endtask

    task automatic pulse_inc();
        cyc(0, 1);
        cyc(0, 0);
    endtask

    task automatic pulse_mode();
        cyc(1, 0);
        cyc(0, 0);
    endtask

    initial begin
        rst      = 1'b1;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_time", 32'(time_date), 32'h123456);
        check("rst_blink", 32'(blink), 32'd0);
        check("rst_carry", 32'(day_carry), 32'd0);
        rst = 1'b0;

        // Free run: 12:34:57 after 4 cycles, 12:34:58 after 8.
        repeat (9) cyc(0, 0);

        // key_inc in RUN is ignored.
        pulse_inc();
        repeat (3) cyc(0, 0);

        // Hours: walk to 22, wrap 23 -> 00, held key gives one step, back to 23.
        pulse_mode();
        for (int i = 0; i < 40 && mhh != 22; i++) pulse_inc();
        pulse_inc();
        pulse_inc();
        repeat (10) cyc(0, 1);
        cyc(0, 0);
        for (int i = 0; i < 40 && mhh != 23; i++) pulse_inc();

        // Minutes: wrap 59 -> 00, back to 59, then mode+inc together.
        pulse_mode();
        for (int i = 0; i < 70 && mmm != 59; i++) pulse_inc();
        pulse_inc();
        for (int i = 0; i < 70 && mmm != 59; i++) pulse_inc();
        cyc(1, 1);
        cyc(0, 0);

        // Seconds to 58, back to RUN, roll the day over.
        for (int i = 0; i < 70 && mss != 58; i++) pulse_inc();
        pulse_mode();
        repeat (12) cyc(0, 0);

        // Mode edge on the same cycle as a tick, then the remaining mode steps.
        for (int i = 0; i < 10 && mpresc != DIV - 1; i++) cyc(0, 0);
        cyc(1, 0);
        cyc(0, 0);
        pulse_mode();
        pulse_mode();
        pulse_mode();
        repeat (6) cyc(0, 0);

        // Async reset mid-operation in SET_SS, key_mode held across release.
        pulse_mode();
        pulse_mode();
        pulse_mode();
        pulse_inc();
        cyc(0, 0);
        #2;
        rst      = 1'b1;
        key_mode = 1'b1;
        #1;
        check("async_time", 32'(time_date), 32'h123456);
        check("async_blink", 32'(blink), 32'd0);
        check("async_carry", 32'(day_carry), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (6) cyc(1, 0);
        repeat (2) cyc(0, 0);
        pulse_mode();
        repeat (3) cyc(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
